// File: rtl/blink_sequencer_pkg.sv
// Shared encodings and 12 MHz timing defaults for the blink sequencer and the pattern generator.
// Timeout compares count the cycles already spent waiting, so a limit of N allows N waiting cycles.
package blink_sequencer_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] ACK   = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    localparam logic BLINK_ERR = 1'b0;
    localparam logic BLINK_OK  = 1'b1;

    localparam logic [31:0] GAP_CYCLES_DFLT  = 32'd2400000;
    localparam logic [31:0] ACK_TIMEOUT_DFLT = 32'd16;
    localparam logic [31:0] RUN_TIMEOUT_DFLT = 32'd120000000;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // True on the last permitted waiting cycle; widened so a limit of 0 still fires.
    function automatic logic timed_out(input logic [31:0] cnt, input logic [31:0] limit);
        return ({1'b0, cnt} + 33'd1) >= {1'b0, limit};
    endfunction

endpackage

// File: rtl/blink_sequencer_req.sv
// Pending-request bit: set wins over a same-cycle clear so no pulse is lost.
// One cycle from set pulse to pend; repeat sets while pending coalesce.
module req_latch (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic pend
);

    logic pend_q;
    logic pend_d;

    always_comb begin
        pend_d = set | (pend_q & ~clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/blink_sequencer.sv
// Arbitrates error/success blink requests onto the shared generator, with timeouts and a dark gap.
// Request pulse to start_blinking is 2 cycles when idle; requests arriving while busy are held pending.
module blink_sequencer
    import blink_sequencer_pkg::*;
#(
    parameter logic [31:0] GAP_CYCLES  = GAP_CYCLES_DFLT,
    parameter logic [31:0] ACK_TIMEOUT = ACK_TIMEOUT_DFLT,
    parameter logic [31:0] RUN_TIMEOUT = RUN_TIMEOUT_DFLT
) (
    input  logic hwclk,
    input  logic rst,
    input  logic err_req,
    input  logic ok_req,
    input  logic done_blinking,
    output logic start_blinking,
    output logic blink_type,
    output logic busy,
    output logic err_served,
    output logic ok_served,
    output logic fault,
    input  logic fault_clr
);

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        type_q, type_d;
    logic        fault_q, fault_d;
    logic        err_srv_q, err_srv_d;
    logic        ok_srv_q, ok_srv_d;

    logic        err_pend, ok_pend;
    logic        err_clr, ok_clr;
    logic        to_set;

    req_latch u_err_latch (
        .clk  (hwclk),
        .rst  (rst),
        .set  (err_req),
        .clr  (err_clr),
        .pend (err_pend)
    );

    req_latch u_ok_latch (
        .clk  (hwclk),
        .rst  (rst),
        .set  (ok_req),
        .clr  (ok_clr),
        .pend (ok_pend)
    );

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        err_clr   = 1'b0;
        ok_clr    = 1'b0;
        err_srv_d = 1'b0;
        ok_srv_d  = 1'b0;
        to_set    = 1'b0;

        case (state_q)
            IDLE: begin
                if (err_pend) begin
                    type_d  = BLINK_ERR;
                    err_clr = 1'b1;
                    state_d = ISSUE;
                end else if (ok_pend) begin
                    type_d  = BLINK_OK;
                    ok_clr  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = ACK;
            end
            ACK: begin
                if (!done_blinking) begin
                    state_d = RUN;
                end else if (timed_out(cnt_q, ACK_TIMEOUT)) begin
                    to_set  = 1'b1;
                    state_d = GAP;
                end
            end
            RUN: begin
                if (done_blinking) begin
                    err_srv_d = (type_q == BLINK_ERR);
                    ok_srv_d  = (type_q == BLINK_OK);
                    state_d   = GAP;
                end else if (timed_out(cnt_q, RUN_TIMEOUT)) begin
                    to_set  = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q >= GAP_CYCLES) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // One counter serves every state; it restarts from zero on each state entry.
        cnt_d   = (state_d != state_q) ? 32'd0 : sat_inc(cnt_q);
        fault_d = to_set | (fault_q & ~fault_clr);
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 32'd0;
            type_q    <= BLINK_ERR;
            fault_q   <= 1'b0;
            err_srv_q <= 1'b0;
            ok_srv_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            type_q    <= type_d;
            fault_q   <= fault_d;
            err_srv_q <= err_srv_d;
            ok_srv_q  <= ok_srv_d;
        end
    end

    assign start_blinking = (state_q == ISSUE);
    assign blink_type     = type_q;
    assign busy           = (state_q != IDLE);
    assign err_served     = err_srv_q;
    assign ok_served      = ok_srv_q;
    assign fault          = fault_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Self-checking bench for blink_sequencer with a cycle-level generator model and a transaction-level reference.
module tb_blink_sequencer;

    localparam int GAP_T   = 4;
    localparam int ACK_T   = 3;
    localparam int RUN_T   = 20;
    localparam int GEN_LOW = 8;
    // start -> served pulse: one ACK cycle, GEN_LOW RUN cycles, then the pulse in the first gap cycle
    localparam int SRV_OFF  = 1 + GEN_LOW + 1;
    // busy from the start cycle through the end of the GAP_T+1 gap cycles
    localparam int BUSY_LEN = SRV_OFF + GAP_T + 1;

    localparam int GEN_NORMAL   = 0;
    localparam int GEN_NO_DROP  = 1;
    localparam int GEN_NO_RAISE = 2;

    logic hwclk = 1'b0;
    logic rst = 1'b1;
    logic err_req = 1'b0;
    logic ok_req = 1'b0;
    logic done_blinking = 1'b1;
    logic fault_clr = 1'b0;
    logic start_blinking, blink_type, busy, err_served, ok_served, fault;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    blink_sequencer #(
        .GAP_CYCLES  (32'd4),
        .ACK_TIMEOUT (32'd3),
        .RUN_TIMEOUT (32'd20)
    ) dut (
        .hwclk          (hwclk),
        .rst            (rst),
        .err_req        (err_req),
        .ok_req         (ok_req),
        .done_blinking  (done_blinking),
        .start_blinking (start_blinking),
        .blink_type     (blink_type),
        .busy           (busy),
        .err_served     (err_served),
        .ok_served      (ok_served),
        .fault          (fault),
        .fault_clr      (fault_clr)
    );

    always #5 hwclk = ~hwclk;
    always @(posedge hwclk) cyc <= cyc + 1;

    // Generator: done falls the cycle after a start and rises GEN_LOW cycles later.
    int gen_mode = GEN_NORMAL;
    int gen_age = -1;
    always @(negedge hwclk) begin
        if (start_blinking) gen_age = 0;
        else if (gen_age >= 0) gen_age = gen_age + 1;
        if (gen_age == 1 && gen_mode != GEN_NO_DROP) done_blinking = 1'b0;
        if (gen_age == GEN_LOW + 1) begin
            if (gen_mode == GEN_NORMAL) done_blinking = 1'b1;
            gen_age = -1;
        end else if (gen_age < 0 && gen_mode == GEN_NORMAL) begin
            done_blinking = 1'b1;
        end
    end

    // Reference: pending bits, fixed error priority, and fixed service duration with a normal generator.
    bit   chk_en = 1'b0;
    bit   m_err, m_ok;
    int   exp_start, next_free;
    logic exp_type;
    int   n_start, n_err_srv, n_ok_srv, first_start_cyc, last_srv_cyc, busy_fall_cyc;
    logic prev_busy;
    logic starts_q[$];

    always @(negedge hwclk) begin
        if (chk_en) begin
            checks++;
            if (start_blinking !== (cyc == exp_start)) begin
                errors++;
                $display("FAIL start_pulse cyc=%0d got=%b want=%b", cyc, start_blinking, cyc == exp_start);
            end
            if (cyc >= exp_start && cyc < exp_start + SRV_OFF) begin
                checks++;
                if (blink_type !== exp_type) begin
                    errors++;
                    $display("FAIL blink_type cyc=%0d got=%b want=%b", cyc, blink_type, exp_type);
                end
            end
            checks++;
            if (err_served !== (cyc == exp_start + SRV_OFF && exp_type == 1'b0)) begin
                errors++;
                $display("FAIL err_served cyc=%0d got=%b", cyc, err_served);
            end
            checks++;
            if (ok_served !== (cyc == exp_start + SRV_OFF && exp_type == 1'b1)) begin
                errors++;
                $display("FAIL ok_served cyc=%0d got=%b", cyc, ok_served);
            end
            checks++;
            if (busy !== (cyc >= exp_start && cyc < exp_start + BUSY_LEN)) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy,
                         cyc >= exp_start && cyc < exp_start + BUSY_LEN);
            end
            checks++;
            if (fault !== 1'b0) begin
                errors++;
                $display("FAIL fault_quiet cyc=%0d got=%b want=0", cyc, fault);
            end

            if (start_blinking) begin
                n_start++;
                starts_q.push_back(blink_type);
                if (n_start == 1) first_start_cyc = cyc;
            end
            if (err_served) n_err_srv++;
            if (ok_served) n_ok_srv++;
            if (err_served || ok_served) last_srv_cyc = cyc;
            if (prev_busy && !busy) busy_fall_cyc = cyc;
            prev_busy = busy;

            if (cyc >= next_free && (m_err || m_ok)) begin
                exp_start = cyc + 1;
                exp_type  = m_err ? 1'b0 : 1'b1;
                if (m_err) m_err = 1'b0;
                else m_ok = 1'b0;
                next_free = exp_start + BUSY_LEN;
            end
            m_err = m_err | err_req;
            m_ok  = m_ok | ok_req;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge hwclk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (busy || !done_blinking); i++) tick(1);
        checks++;
        if (busy || !done_blinking) begin
            errors++;
            $display("FAIL idle_timeout busy=%b done=%b want busy=0 done=1", busy, done_blinking);
        end
    endtask

    task automatic sync_model();
        wait_idle();
        m_err = 0; m_ok = 0;
        exp_start = -100; next_free = 0; exp_type = 1'b0;
        n_start = 0; n_err_srv = 0; n_ok_srv = 0;
        first_start_cyc = -1; last_srv_cyc = -1; busy_fall_cyc = -1;
        prev_busy = 1'b0;
        starts_q.delete();
        chk_en = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        tick(3);
        checks++;
        if (busy !== 1'b0 || start_blinking !== 1'b0 || blink_type !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b start=%b type=%b want 000", busy, start_blinking, blink_type);
        end
        checks++;
        if (err_served !== 1'b0 || ok_served !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags err_srv=%b ok_srv=%b fault=%b want 000", err_served, ok_served, fault);
        end
        rst = 1'b0;
        tick(2);
        ok_req = 1'b1; tick(1); ok_req = 1'b0;
        for (int i = 0; i < 10 && !start_blinking; i++) tick(1);
        tick(4);
        err_req = 1'b1; tick(1); err_req = 1'b0;
        tick(1);
        rst = 1'b1; tick(1); rst = 1'b0;
        checks++;
        if (dut.state_q !== blink_sequencer_pkg::IDLE || busy !== 1'b0 || start_blinking !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run state=%0d busy=%b start=%b want 0 0 0", dut.state_q, busy, start_blinking);
        end
        checks++;
        if (dut.u_err_latch.pend_q !== 1'b0 || dut.u_ok_latch.pend_q !== 1'b0 || fault !== 1'b0 ||
            err_served !== 1'b0 || ok_served !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run_flags err_pend=%b ok_pend=%b fault=%b srv=%b%b want 0",
                     dut.u_err_latch.pend_q, dut.u_ok_latch.pend_q, fault, err_served, ok_served);
        end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (start_blinking) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL reset_drops_pending starts=%0d want 0", n);
        end
    endtask

    task automatic test_single_ok();
        int t;
        sync_model();
        tick(2);
        t = cyc;
        ok_req = 1'b1; tick(1); ok_req = 1'b0;
        tick(40);
        checks++;
        if (n_start != 1 || first_start_cyc != t + 2) begin
            errors++;
            $display("FAIL single_start count=%0d at=%0d want 1 at %0d", n_start, first_start_cyc, t + 2);
        end
        checks++;
        if (n_ok_srv != 1 || n_err_srv != 0) begin
            errors++;
            $display("FAIL single_served ok=%0d err=%0d want 1 0", n_ok_srv, n_err_srv);
        end
        checks++;
        if (busy_fall_cyc != last_srv_cyc + GAP_T + 1) begin
            errors++;
            $display("FAIL single_busy_fall at=%0d want %0d", busy_fall_cyc, last_srv_cyc + GAP_T + 1);
        end
        chk_en = 1'b0;
    endtask

    task automatic test_same_cycle();
        sync_model();
        tick(2);
        err_req = 1'b1; ok_req = 1'b1; tick(1); err_req = 1'b0; ok_req = 1'b0;
        tick(60);
        checks++;
        if (n_start != 2) begin
            errors++;
            $display("FAIL both_start_count got=%0d want 2", n_start);
        end else begin
            checks++;
            if (starts_q[0] !== 1'b0 || starts_q[1] !== 1'b1) begin
                errors++;
                $display("FAIL both_order got=%b,%b want 0,1", starts_q[0], starts_q[1]);
            end
        end
        checks++;
        if (n_err_srv != 1 || n_ok_srv != 1) begin
            errors++;
            $display("FAIL both_served err=%0d ok=%0d want 1 1", n_err_srv, n_ok_srv);
        end
        chk_en = 1'b0;
    endtask

    task automatic test_coalesce();
        sync_model();
        ok_req = 1'b1; tick(1); ok_req = 1'b0;
        for (int i = 0; i < 10 && n_start == 0; i++) tick(1);
        tick(4);
        for (int k = 0; k < 3; k++) begin
            ok_req = 1'b1; tick(1); ok_req = 1'b0; tick(1);
        end
        tick(60);
        checks++;
        if (n_start != 2 || n_ok_srv != 2 || n_err_srv != 0) begin
            errors++;
            $display("FAIL coalesce starts=%0d ok=%0d err=%0d want 2 2 0", n_start, n_ok_srv, n_err_srv);
        end
        chk_en = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] r;
        sync_model();
        for (int k = 0; k < 30; k++) begin
            tick($urandom_range(0, 20));
            r = 2'($urandom_range(1, 3));
            err_req = r[0]; ok_req = r[1];
            tick(1);
            err_req = 1'b0; ok_req = 1'b0;
        end
        for (int i = 0; i < 2000 && (m_err || m_ok || cyc <= next_free); i++) tick(1);
        checks++;
        if (m_err || m_ok || cyc <= next_free) begin
            errors++;
            $display("FAIL random_drain pending=%b%b cyc=%0d want drained by %0d", m_err, m_ok, cyc, next_free);
        end
        checks++;
        if (n_start == 0 || n_err_srv + n_ok_srv != n_start) begin
            errors++;
            $display("FAIL random_served starts=%0d served=%0d want equal and nonzero", n_start, n_err_srv + n_ok_srv);
        end
        chk_en = 1'b0;
    endtask

    task automatic test_ack_timeout();
        int s, fault_at, fall_at, srv;
        wait_idle();
        gen_mode = GEN_NO_DROP;
        ok_req = 1'b1; tick(1); ok_req = 1'b0;
        for (int i = 0; i < 10 && !start_blinking; i++) tick(1);
        s = cyc; fault_at = -1; fall_at = -1; srv = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (fault && fault_at < 0) fault_at = cyc;
            if (!busy && fall_at < 0) fall_at = cyc;
            if (ok_served || err_served) srv++;
        end
        checks++;
        if (fault_at != s + 1 + ACK_T) begin
            errors++;
            $display("FAIL ack_fault_at got=%0d want %0d", fault_at, s + 1 + ACK_T);
        end
        checks++;
        if (srv != 0 || fall_at != s + 1 + ACK_T + GAP_T + 1) begin
            errors++;
            $display("FAIL ack_gap served=%0d idle_at=%0d want 0 %0d", srv, fall_at, s + 1 + ACK_T + GAP_T + 1);
        end
        fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_clr got=%b want 0", fault);
        end
        ok_req = 1'b1; tick(1); ok_req = 1'b0;
        for (int i = 0; i < 10 && !start_blinking; i++) tick(1);
        tick(ACK_T);
        fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_set_wins got=%b want 1", fault);
        end
        wait_idle();
        gen_mode = GEN_NORMAL;
        fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
    endtask

    task automatic test_run_timeout();
        int s, fault_at, s2, ok_n, err_n;
        logic t2;
        wait_idle();
        gen_mode = GEN_NO_RAISE;
        ok_req = 1'b1; tick(1); ok_req = 1'b0;
        for (int i = 0; i < 10 && !start_blinking; i++) tick(1);
        s = cyc; fault_at = -1; s2 = -1; t2 = 1'bx; ok_n = 0; err_n = 0;
        for (int k = 1; k <= 45; k++) begin
            tick(1);
            if (fault && fault_at < 0) begin
                fault_at = cyc;
                gen_mode = GEN_NORMAL;
            end
            if (start_blinking && s2 < 0) begin
                s2 = cyc;
                t2 = blink_type;
            end
            if (ok_served) ok_n++;
            if (err_served) err_n++;
            err_req = (k == 3);
        end
        err_req = 1'b0;
        checks++;
        if (fault_at != s + 2 + RUN_T) begin
            errors++;
            $display("FAIL run_fault_at got=%0d want %0d", fault_at, s + 2 + RUN_T);
        end
        checks++;
        if (s2 != s + 2 + RUN_T + GAP_T + 2 || t2 !== 1'b0) begin
            errors++;
            $display("FAIL queued_err_start at=%0d type=%b want %0d 0", s2, t2, s + 2 + RUN_T + GAP_T + 2);
        end
        checks++;
        if (ok_n != 0 || err_n != 1 || fault !== 1'b1) begin
            errors++;
            $display("FAIL run_served ok=%0d err=%0d fault=%b want 0 1 1", ok_n, err_n, fault);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_ok();
        test_same_cycle();
        test_coalesce();
        test_random();
        test_ack_timeout();
        test_run_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
